// File: rtl/sync_pkg.sv
// Shared state encodings and field widths for the SOP acquisition controller.
package sync_pkg;

    localparam int FRAME_W = 24;
    localparam int SOP_W   = 19;
    localparam int TALLY_W = 8;
    localparam int MISS_W  = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TRAIN  = 3'd1;
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_LOCK   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_TRAIN  = ST_TRAIN,
        S_VERIFY = ST_VERIFY,
        S_LOCK   = ST_LOCK,
        S_HOLD   = ST_HOLD
    } sync_state_e;

    function automatic logic is_tracking(input logic [2:0] st);
        return (st == ST_LOCK) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/sync_flywheel.sv
// Free-running SOP phase counter with the acceptance window around phase 0;
// flags accepted SOPs and windows that closed without one.
module sync_flywheel
    import sync_pkg::*;
#(
    parameter int pWIN = 16
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic [SOP_W-1:0] time_sop,
    input  logic             active,
    input  logic             run,
    input  logic             load,
    input  logic             sop_vrf,
    output logic             accept,
    output logic             miss,
    output logic             sop
);

    localparam int           XW  = SOP_W + 1;
    localparam logic [XW-1:0] WIN = XW'(pWIN);

    logic [SOP_W-1:0] phase_q;
    logic [SOP_W-1:0] phase_d;
    logic             sop_seen_q;
    logic [XW-1:0]    phase_x;
    logic [XW-1:0]    period_x;
    logic [XW-1:0]    phase_inc;
    logic             win_open;
    logic             win_close;

    // One extra bit so period - WIN cannot wrap into a bogus small threshold.
    assign phase_x   = {1'b0, phase_q};
    assign period_x  = {1'b0, time_sop};
    assign phase_inc = phase_x + XW'(1);
    assign win_open  = (phase_x <= WIN) || (period_x <= WIN) || (phase_x >= period_x - WIN);
    assign win_close = (phase_x == WIN + XW'(1));

    assign accept = active && sop_vrf && win_open;
    assign miss   = active && win_close && !sop_seen_q && !accept;

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_d = '0;
        if (run) begin
            if (load || accept) begin
                phase_d = SOP_W'(1);
            end else if (phase_inc >= period_x) begin
                phase_d = '0;
            end else begin
                phase_d = phase_inc[SOP_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            phase_q    <= '0;
            sop_seen_q <= 1'b0;
            sop        <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sop     <= run && (phase_d == '0);
            if (!run) begin
                sop_seen_q <= 1'b0;
            end else if (load || accept) begin
                sop_seen_q <= 1'b1;
            end else if (win_close) begin
                sop_seen_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sync_acq_ctrl.sv
// Acquisition controller: trains and verifies the detector, then tracks SOP
// with a flywheel and falls back to training after repeated misses.
module sync_acq_ctrl
    import sync_pkg::*;
#(
    parameter int pWIN       = 16,
    parameter int pMISS_MAX  = 4,
    parameter int pTO_FRAMES = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               istart,
    input  logic               imode,
    input  logic [FRAME_W-1:0] iframe_time,
    input  logic [SOP_W-1:0]   itime_sop,
    input  logic               isop,
    input  logic               isop_vrf,
    input  logic               itrh_hold,
    input  logic               ivrf_val,
    output logic               odet_ena,
    output logic               otrh_auto,
    output logic               osync_mode,
    output logic               osop,
    output logic               olock,
    output logic [2:0]         ostate,
    output logic [MISS_W-1:0]  omiss_cnt
);

    localparam logic [TALLY_W:0] TO_LIMIT   = (TALLY_W + 1)'(pTO_FRAMES);
    localparam logic [MISS_W:0]  MISS_LIMIT = (MISS_W + 1)'(pMISS_MAX);

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic [TALLY_W-1:0] tally_q;
    logic [MISS_W-1:0]  miss_cnt_q;
    logic [7:0]         raw_sop_cnt_q;
    logic               tracking;
    logic               run_next;
    logic               fw_load;
    logic               fw_accept;
    logic               fw_miss;
    logic               frame_wrap;
    logic               timeout;
    logic               miss_limit_hit;
    logic               status_unused;

    assign tracking       = is_tracking(state_q);
    assign run_next       = is_tracking(state_d);
    assign frame_wrap     = ({1'b0, frame_cnt_q} + (FRAME_W + 1)'(1)) >= {1'b0, iframe_time};
    assign timeout        = frame_wrap && (({1'b0, tally_q} + (TALLY_W + 1)'(1)) >= TO_LIMIT);
    assign miss_limit_hit = ({1'b0, miss_cnt_q} + (MISS_W + 1)'(1)) >= MISS_LIMIT;

    assign ostate        = state_q;
    assign omiss_cnt     = miss_cnt_q;
    assign status_unused = ^raw_sop_cnt_q;

    always_comb begin
        state_d = state_q;
        fw_load = 1'b0;
        case (state_q)
            ST_IDLE:   state_d = ST_TRAIN;
            ST_TRAIN: begin
                if (itrh_hold)    state_d = ST_VERIFY;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_VERIFY: begin
                if (ivrf_val && isop_vrf) begin
                    state_d = ST_LOCK;
                    fw_load = 1'b1;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (fw_miss) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (fw_accept)                      state_d = ST_LOCK;
                else if (fw_miss && miss_limit_hit) state_d = ST_TRAIN;
            end
            default:   state_d = ST_IDLE;
        endcase
        // Dropping istart wins over every other transition.
        if (!istart) begin
            state_d = ST_IDLE;
            fw_load = 1'b0;
        end
    end

    sync_flywheel #(
        .pWIN(pWIN)
    ) u_flywheel (
        .iclk     (iclk),
        .ireset   (ireset),
        .time_sop (itime_sop),
        .active   (tracking),
        .run      (run_next),
        .load     (fw_load),
        .sop_vrf  (isop_vrf),
        .accept   (fw_accept),
        .miss     (fw_miss),
        .sop      (osop)
    );

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q       <= ST_IDLE;
            frame_cnt_q   <= '0;
            tally_q       <= '0;
            miss_cnt_q    <= '0;
            raw_sop_cnt_q <= '0;
            osync_mode    <= 1'b0;
            olock         <= 1'b0;
            odet_ena      <= 1'b0;
            otrh_auto     <= 1'b0;
        end else begin
            state_q   <= state_d;
            olock     <= run_next;
            odet_ena  <= (state_d != ST_IDLE);
            otrh_auto <= (state_d != ST_IDLE);

            if (state_q == ST_IDLE && istart) begin
                osync_mode <= imode;
            end

            if (fw_load || fw_accept) begin
                miss_cnt_q <= '0;
            end else if (fw_miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + MISS_W'(1);
            end

            // Frame timing restarts with every state entry.
            if (state_d != state_q) begin
                frame_cnt_q <= '0;
                tally_q     <= '0;
            end else if (frame_wrap) begin
                frame_cnt_q <= '0;
                if (tally_q != '1) tally_q <= tally_q + TALLY_W'(1);
            end else begin
                frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
            end

            if (isop) begin
                raw_sop_cnt_q <= raw_sop_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sync_acq_ctrl.sv
// Directed bench for sync_acq_ctrl: acquisition, window re-centring, hold/miss
// handling, timeouts, istart drop and asynchronous reset.
module tb_sync_acq_ctrl;

    localparam int TSOP = 1000;

    logic        iclk = 1'b0;
    logic        ireset;
    logic        istart;
    logic        imode;
    logic [23:0] iframe_time;
    logic [18:0] itime_sop;
    logic        isop;
    logic        isop_vrf;
    logic        itrh_hold;
    logic        ivrf_val;
    logic        odet_ena;
    logic        otrh_auto;
    logic        osync_mode;
    logic        osop;
    logic        olock;
    logic [2:0]  ostate;
    logic [3:0]  omiss_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int ph      = 0;

    sync_acq_ctrl dut (
        .iclk        (iclk),
        .ireset      (ireset),
        .istart      (istart),
        .imode       (imode),
        .iframe_time (iframe_time),
        .itime_sop   (itime_sop),
        .isop        (isop),
        .isop_vrf    (isop_vrf),
        .itrh_hold   (itrh_hold),
        .ivrf_val    (ivrf_val),
        .odet_ena    (odet_ena),
        .otrh_auto   (otrh_auto),
        .osync_mode  (osync_mode),
        .osop        (osop),
        .olock       (olock),
        .ostate      (ostate),
        .omiss_cnt   (omiss_cnt)
    );

    always #5 iclk = ~iclk;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    // Expected flywheel phase advances by one per clock when no SOP is taken.
    task automatic step();
        tick();
        ph = (ph == TSOP - 1) ? 0 : ph + 1;
    endtask

    task automatic advance_to(input int target);
        do step(); while (ph != target);
    endtask

    task automatic pulse_sop_vrf();
        isop_vrf = 1'b1;
        tick();
        isop_vrf = 1'b0;
    endtask

    task automatic test_reset();
        ireset = 1'b0;
        #12;
        n_total++; if (ostate !== 3'd0)    $display("FAIL reset_state: got %0d want 0", ostate); else n_pass++;
        n_total++; if (olock !== 1'b0)     $display("FAIL reset_lock: got %b want 0", olock); else n_pass++;
        n_total++; if (odet_ena !== 1'b0)  $display("FAIL reset_det_ena: got %b want 0", odet_ena); else n_pass++;
        n_total++; if (otrh_auto !== 1'b0) $display("FAIL reset_trh_auto: got %b want 0", otrh_auto); else n_pass++;
        n_total++; if (osync_mode !== 1'b0) $display("FAIL reset_sync_mode: got %b want 0", osync_mode); else n_pass++;
        n_total++; if (osop !== 1'b0)      $display("FAIL reset_sop: got %b want 0", osop); else n_pass++;
        n_total++; if (omiss_cnt !== 4'd0) $display("FAIL reset_miss_cnt: got %0d want 0", omiss_cnt); else n_pass++;
        #11 ireset = 1'b1;
        repeat (3) tick();
        n_total++; if (ostate !== 3'd0) $display("FAIL idle_without_start: got %0d want 0", ostate); else n_pass++;
    endtask

    task automatic test_acquire();
        imode  = 1'b1;
        istart = 1'b1;
        tick();
        n_total++; if (ostate !== 3'd1)     $display("FAIL acq_train: got %0d want 1", ostate); else n_pass++;
        n_total++; if (osync_mode !== 1'b1) $display("FAIL acq_mode_latch: got %b want 1", osync_mode); else n_pass++;
        n_total++; if (otrh_auto !== 1'b1)  $display("FAIL acq_trh_auto: got %b want 1", otrh_auto); else n_pass++;
        imode = 1'b0;
        repeat (48) tick();
        n_total++; if (ostate !== 3'd1) $display("FAIL acq_train_wait: got %0d want 1", ostate); else n_pass++;
        itrh_hold = 1'b1;
        tick();
        itrh_hold = 1'b0;
        n_total++; if (ostate !== 3'd2)     $display("FAIL acq_verify: got %0d want 2", ostate); else n_pass++;
        n_total++; if (osync_mode !== 1'b1) $display("FAIL acq_mode_hold: got %b want 1", osync_mode); else n_pass++;
        repeat (48) tick();
        ivrf_val = 1'b1;
        tick();
        n_total++; if (ostate !== 3'd2) $display("FAIL acq_vrf_only: got %0d want 2", ostate); else n_pass++;
        isop_vrf = 1'b1;
        tick();
        isop_vrf = 1'b0;
        ivrf_val = 1'b0;
        ph = 1;
        n_total++; if (ostate !== 3'd3) $display("FAIL acq_lock: got %0d want 3", ostate); else n_pass++;
        n_total++; if (olock !== 1'b1)  $display("FAIL acq_olock: got %b want 1", olock); else n_pass++;
        n_total++; if (osop !== 1'b0)   $display("FAIL acq_sop_at_ph1: got %b want 0", osop); else n_pass++;
    endtask

    task automatic test_lock_window();
        advance_to(16);
        pulse_sop_vrf();
        ph = 1;
        n_total++; if (ostate !== 3'd3)    $display("FAIL win_hi_edge_state: got %0d want 3", ostate); else n_pass++;
        advance_to(995);
        pulse_sop_vrf();
        ph = 1;
        n_total++; if (ostate !== 3'd3)    $display("FAIL recentre_state: got %0d want 3", ostate); else n_pass++;
        n_total++; if (omiss_cnt !== 4'd0) $display("FAIL recentre_miss: got %0d want 0", omiss_cnt); else n_pass++;
        advance_to(500);
        pulse_sop_vrf();
        ph = 501;
        advance_to(983);
        pulse_sop_vrf();
        ph = 984;
        n_total++; if (ostate !== 3'd3) $display("FAIL outside_ignored_state: got %0d want 3", ostate); else n_pass++;
        advance_to(999);
        n_total++; if (osop !== 1'b0) $display("FAIL sop_before_wrap: got %b want 0", osop); else n_pass++;
        step();
        n_total++; if (osop !== 1'b1) $display("FAIL sop_at_wrap: got %b want 1", osop); else n_pass++;
    endtask

    task automatic test_hold();
        advance_to(17);
        n_total++; if (ostate !== 3'd3) $display("FAIL hold_not_yet: got %0d want 3", ostate); else n_pass++;
        step();
        n_total++; if (ostate !== 3'd4)    $display("FAIL hold_entry: got %0d want 4", ostate); else n_pass++;
        n_total++; if (olock !== 1'b1)     $display("FAIL hold_olock: got %b want 1", olock); else n_pass++;
        n_total++; if (omiss_cnt !== 4'd1) $display("FAIL hold_miss1: got %0d want 1", omiss_cnt); else n_pass++;
        advance_to(0);
        n_total++; if (osop !== 1'b1) $display("FAIL hold_flywheel_sop: got %b want 1", osop); else n_pass++;
        advance_to(18);
        n_total++; if (omiss_cnt !== 4'd2) $display("FAIL hold_miss2: got %0d want 2", omiss_cnt); else n_pass++;
        advance_to(990);
        pulse_sop_vrf();
        ph = 1;
        n_total++; if (ostate !== 3'd3)    $display("FAIL hold_recover: got %0d want 3", ostate); else n_pass++;
        n_total++; if (omiss_cnt !== 4'd0) $display("FAIL hold_recover_miss: got %0d want 0", omiss_cnt); else n_pass++;
        advance_to(18);
        n_total++; if (ostate !== 3'd3) $display("FAIL relock_first_close: got %0d want 3", ostate); else n_pass++;
        advance_to(18);
        advance_to(18);
        advance_to(18);
        n_total++; if (omiss_cnt !== 4'd3) $display("FAIL hold_miss3: got %0d want 3", omiss_cnt); else n_pass++;
        advance_to(17);
        n_total++; if (ostate !== 3'd4) $display("FAIL hold_before_limit: got %0d want 4", ostate); else n_pass++;
        step();
        n_total++; if (ostate !== 3'd1)    $display("FAIL miss_limit_train: got %0d want 1", ostate); else n_pass++;
        n_total++; if (olock !== 1'b0)     $display("FAIL miss_limit_olock: got %b want 0", olock); else n_pass++;
        n_total++; if (omiss_cnt !== 4'd4) $display("FAIL miss_limit_cnt: got %0d want 4", omiss_cnt); else n_pass++;
    endtask

    task automatic test_istart_drop();
        itrh_hold = 1'b1;
        tick();
        itrh_hold = 1'b0;
        ivrf_val  = 1'b1;
        isop_vrf  = 1'b1;
        tick();
        ivrf_val  = 1'b0;
        isop_vrf  = 1'b0;
        ph = 1;
        advance_to(18);
        advance_to(18);
        n_total++; if (ostate !== 3'd4) $display("FAIL drop_pre_hold: got %0d want 4", ostate); else n_pass++;
        istart = 1'b0;
        tick();
        n_total++; if (ostate !== 3'd0)     $display("FAIL drop_idle: got %0d want 0", ostate); else n_pass++;
        n_total++; if (olock !== 1'b0)      $display("FAIL drop_olock: got %b want 0", olock); else n_pass++;
        n_total++; if (odet_ena !== 1'b0)   $display("FAIL drop_det_ena: got %b want 0", odet_ena); else n_pass++;
        n_total++; if (osync_mode !== 1'b1) $display("FAIL drop_mode_kept: got %b want 1", osync_mode); else n_pass++;
    endtask

    task automatic test_timeout();
        imode       = 1'b0;
        iframe_time = 24'd100;
        istart      = 1'b1;
        tick();
        n_total++; if (ostate !== 3'd1)     $display("FAIL to_train: got %0d want 1", ostate); else n_pass++;
        n_total++; if (osync_mode !== 1'b0) $display("FAIL to_mode_relatch: got %b want 0", osync_mode); else n_pass++;
        repeat (799) tick();
        n_total++; if (otrh_auto !== 1'b1) $display("FAIL to_train_799: got %b want 1", otrh_auto); else n_pass++;
        tick();
        n_total++; if (otrh_auto !== 1'b0) $display("FAIL to_trh_low: got %b want 0", otrh_auto); else n_pass++;
        n_total++; if (ostate !== 3'd0)    $display("FAIL to_restart_state: got %0d want 0", ostate); else n_pass++;
        tick();
        n_total++; if (otrh_auto !== 1'b1) $display("FAIL to_trh_back: got %b want 1", otrh_auto); else n_pass++;
        n_total++; if (ostate !== 3'd1)    $display("FAIL to_retrain: got %0d want 1", ostate); else n_pass++;
        itrh_hold = 1'b1;
        tick();
        itrh_hold = 1'b0;
        repeat (799) tick();
        n_total++; if (ostate !== 3'd2) $display("FAIL to_verify_799: got %0d want 2", ostate); else n_pass++;
        tick();
        n_total++; if (ostate !== 3'd0) $display("FAIL to_verify_restart: got %0d want 0", ostate); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_lock();
        iframe_time = 24'd100000;
        itrh_hold   = 1'b1;
        tick();
        itrh_hold = 1'b0;
        ivrf_val  = 1'b1;
        isop_vrf  = 1'b1;
        tick();
        ivrf_val  = 1'b0;
        isop_vrf  = 1'b0;
        n_total++; if (olock !== 1'b1) $display("FAIL rst_pre_lock: got %b want 1", olock); else n_pass++;
        #3 ireset = 1'b0;
        #1;
        n_total++; if (ostate !== 3'd0)    $display("FAIL rst_async_state: got %0d want 0", ostate); else n_pass++;
        n_total++; if (olock !== 1'b0)     $display("FAIL rst_async_lock: got %b want 0", olock); else n_pass++;
        n_total++; if (odet_ena !== 1'b0)  $display("FAIL rst_async_det: got %b want 0", odet_ena); else n_pass++;
        n_total++; if (otrh_auto !== 1'b0) $display("FAIL rst_async_trh: got %b want 0", otrh_auto); else n_pass++;
        repeat (2) @(posedge iclk);
        #3 ireset = 1'b1;
        tick();
        n_total++; if (ostate !== 3'd1) $display("FAIL rst_release_train: got %0d want 1", ostate); else n_pass++;
    endtask

    initial begin
        ireset      = 1'b0;
        istart      = 1'b0;
        imode       = 1'b0;
        iframe_time = 24'd100000;
        itime_sop   = 19'(TSOP);
        isop        = 1'b0;
        isop_vrf    = 1'b0;
        itrh_hold   = 1'b0;
        ivrf_val    = 1'b0;

        test_reset();
        test_acquire();
        test_lock_window();
        test_hold();
        test_istart_drop();
        test_timeout();
        test_reset_mid_lock();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_acq_ctrl.md
SYNC_ACQ_CTRL -- requirements
Module: sync_acq_ctrl

Interface
REQ-001 Parameter pWIN, default 16: half-width in clocks of the SOP acceptance window around the predicted SOP.
REQ-002 Parameter pMISS_MAX, default 4: consecutive missed SOPs tolerated in HOLD before loss of lock.
REQ-003 Parameter pTO_FRAMES, default 8: frames allowed in TRAIN or VERIFY before restart.
REQ-004 Reset is ireset, asynchronous, active-low; clock is iclk.
REQ-005 iclk  in  1  system clock.
REQ-006 ireset  in  1  asynchronous active-low reset.
REQ-007 istart  in  1  level; 1 = acquisition enabled, 0 = return to IDLE.
REQ-008 imode  in  1  requested detector sync mode, sampled only in IDLE.
REQ-009 iframe_time  in  24  frame length in clocks.
REQ-010 itime_sop  in  19  nominal SOP period in clocks.
REQ-011 isop  in  1  raw detector SOP pulse.
REQ-012 isop_vrf  in  1  verified detector SOP pulse.
REQ-013 itrh_hold  in  1  detector threshold converged.
REQ-014 ivrf_val  in  1  detector verification passed.
REQ-015 odet_ena  out  1  detector enable.
REQ-016 otrh_auto  out  1  detector auto-threshold enable.
REQ-017 osync_mode  out  1  latched sync mode to detector.
REQ-018 osop  out  1  flywheel SOP strobe, one clock.
REQ-019 olock  out  1  1 in LOCK or HOLD.
REQ-020 ostate  out  3  encoded FSM state.
REQ-021 omiss_cnt  out  4  consecutive missed-SOP count.

Function
REQ-022 FSM states and encoding: IDLE=0, TRAIN=1, VERIFY=2, LOCK=3, HOLD=4.
REQ-023 IDLE: odet_ena=otrh_auto=0; on istart=1 latch imode into osync_mode, go TRAIN next clock.
REQ-024 TRAIN: odet_ena=otrh_auto=1; itrh_hold=1 -> VERIFY.
REQ-025 VERIFY: odet_ena=otrh_auto=1; ivrf_val=1 and isop_vrf=1 in the same clock -> LOCK, flywheel phase loaded to 1.
REQ-026 Timeout: 24-bit frame counter wraps at iframe_time-1 and 8-bit frame tally counts wraps; tally reaching pTO_FRAMES in TRAIN or VERIFY -> IDLE-equivalent restart (otrh_auto low for exactly one clock, then TRAIN).
REQ-027 Frame counter and tally clear on every state entry.
REQ-028 Flywheel: 19-bit phase counter active in LOCK/HOLD, counts 0..itime_sop-1 and wraps; osop=1 when phase==0.
REQ-029 Window open when phase<=pWIN or phase>=itime_sop-pWIN; window arithmetic carried at 20 bits, no underflow when itime_sop<pWIN (window then always open).
REQ-030 LOCK: isop_vrf inside window -> phase reloads to 1 (re-centre), omiss_cnt=0; isop_vrf outside window ignored.
REQ-031 A window closing (phase==pWIN+1) with no accepted isop_vrf since it opened counts one miss; LOCK -> HOLD on first miss.
REQ-032 HOLD: flywheel keeps running, osop keeps firing; accepted isop_vrf -> LOCK with omiss_cnt=0; omiss_cnt reaching pMISS_MAX -> TRAIN.
REQ-033 omiss_cnt saturates at 15.
REQ-034 istart=0 in any state -> IDLE next clock, overrides all other transitions; osync_mode keeps its last value.
REQ-035 isop is counted only for status; it never changes state.
REQ-036 Simultaneous isop_vrf and window close in the same clock: accept the SOP, no miss.
REQ-037 osop, olock, ostate are registered outputs; latency from accepting isop_vrf to phase==1 is one clock.

Reset
REQ-038 On ireset=0: state IDLE, all counters 0, odet_ena=otrh_auto=osync_mode=osop=olock=0, ostate=0, omiss_cnt=0.
REQ-039 Reset released mid-frame: first state change occurs on the first clock after release that sees istart=1.

Structure
REQ-040 State enum type and state encodings reside in shared package sync_pkg, alongside the widths 24/19.
REQ-041 Flywheel phase counter plus window logic form one sub-module, sync_flywheel.

Verification
REQ-042 istart=1, itrh_hold rises at clock 50, ivrf_val and isop_vrf at clock 100 -> ostate 0->1->2->3, olock=1 at clock 101.
REQ-043 LOCK, itime_sop=1000, isop_vrf at phase 995 -> accepted, phase=1 next clock, omiss_cnt stays 0.
REQ-044 LOCK, isop_vrf stopped -> HOLD after first window, osop every 1000 clocks, TRAIN after 4 misses.
REQ-045 TRAIN with itrh_hold=0, iframe_time=100 -> otrh_auto low one clock at clock 800, re-enters TRAIN.
REQ-046 istart dropped while in HOLD -> IDLE next clock; ireset asserted mid-LOCK -> all outputs 0 immediately.
